// File: rtl/cbus_rr_arbiter.sv
// cbus_rr_arbiter: grants one of NUM_INPUTS CBus masters access to the single
// memory-side CBus. The grant is held for a whole transaction, including all
// burst beats, and is released on the last handshake or when the granted
// master drops valid.
// Configuration macro: CBUS_ARB_RR_EN
//   defined   -> round-robin priority starting after the last completed grant
//   undefined -> fixed priority, lowest valid index wins
// oreq/iresps are combinational from the registered grant state plus the
// live ireqs/oresp; there is no data-path register.

package cbus_pkg;

  localparam int unsigned CBUS_ADDR_W = 32;
  localparam int unsigned CBUS_DATA_W = 32;
  localparam int unsigned CBUS_STRB_W = CBUS_DATA_W / 8;
  localparam int unsigned CBUS_LEN_W  = 4;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10
  } cbus_burst_t;

  // Master-to-memory request payload.
  typedef struct packed {
    logic                   valid;
    logic                   is_write;
    logic [2:0]             size;
    logic [CBUS_ADDR_W-1:0] addr;
    logic [CBUS_STRB_W-1:0] strobe;
    logic [CBUS_DATA_W-1:0] data;
    logic [CBUS_LEN_W-1:0]  len;
    cbus_burst_t            burst;
  } cbus_req_t;

  // Memory-to-master response payload.
  typedef struct packed {
    logic                   ready;
    logic                   last;
    logic [CBUS_DATA_W-1:0] data;
  } cbus_resp_t;

endpackage

module cbus_rr_arbiter
  import cbus_pkg::*;
#(
  parameter int unsigned NUM_INPUTS = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  cbus_req_t  [NUM_INPUTS-1:0]  ireqs,
  output cbus_resp_t [NUM_INPUTS-1:0]  iresps,
  output cbus_req_t                    oreq,
  input  cbus_resp_t                   oresp
);

  localparam int unsigned SEL_W = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t             state;
  state_t             state_next;
  logic [SEL_W-1:0]   sel;
  logic [SEL_W-1:0]   sel_next;
  logic [NUM_INPUTS-1:0] valids;
  logic               any_valid;
  logic [SEL_W-1:0]   winner;
  logic               sel_valid;
  logic               last_beat;

`ifdef CBUS_ARB_RR_EN
  logic [SEL_W-1:0]   last_grant;
  logic [SEL_W-1:0]   last_grant_next;
`endif

  // Gather request valids into a vector for the priority search.
  always_comb begin
    valids = '0;
    for (int unsigned i = 0; i < NUM_INPUTS; i++) begin
      valids[i] = ireqs[i].valid;
    end
  end

  assign any_valid = |valids;

`ifdef CBUS_ARB_RR_EN
  // Round-robin search: first valid index starting at last_grant+1 (mod N).
  // Walking the offsets downwards lets the smallest offset win the last write.
  always_comb begin
    winner = '0;
    for (int unsigned k = NUM_INPUTS; k >= 1; k--) begin
      int unsigned idx;
      idx = (32'(last_grant) + k) % NUM_INPUTS;
      if (valids[idx]) begin
        winner = SEL_W'(idx);
      end
    end
  end
`else
  // Fixed priority search: the lowest valid index wins.
  always_comb begin
    winner = '0;
    for (int i = int'(NUM_INPUTS) - 1; i >= 0; i--) begin
      if (valids[i]) begin
        winner = SEL_W'(i);
      end
    end
  end
`endif

  // Status of the currently selected master and memory handshake.
  assign sel_valid = ireqs[sel].valid;
  assign last_beat = oresp.ready && oresp.last;

  // Grant state registers; reset leaves input 0 as the first winner.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      sel        <= '0;
`ifdef CBUS_ARB_RR_EN
      last_grant <= SEL_W'(NUM_INPUTS - 1);
`endif
    end else begin
      state      <= state_next;
      sel        <= sel_next;
`ifdef CBUS_ARB_RR_EN
      last_grant <= last_grant_next;
`endif
    end
  end

  // Next-state and bus steering: idle outputs are zero, busy routes sel.
  always_comb begin
    state_next      = state;
    sel_next        = sel;
`ifdef CBUS_ARB_RR_EN
    last_grant_next = last_grant;
`endif
    oreq            = '0;
    iresps          = '0;

    unique case (state)
      IDLE: begin
        if (any_valid) begin
          sel_next   = winner;
          state_next = BUSY;
        end
      end

      BUSY: begin
        oreq        = ireqs[sel];
        iresps[sel] = oresp;
        if (!sel_valid) begin
          // Master abandoned its transaction; release without updating priority.
          state_next = IDLE;
        end else if (last_beat) begin
          state_next      = IDLE;
`ifdef CBUS_ARB_RR_EN
          last_grant_next = sel;
`endif
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_cbus_rr_arbiter.sv
// Directed bench for cbus_rr_arbiter with NUM_INPUTS = 2. Inputs are driven
// 1 time unit after the rising edge, outputs sampled on the falling edge.
// Expected grant order is queued when requests are driven and checked by a
// monitor whenever a new transaction appears on oreq.

module tb_cbus_rr_arbiter;
  import cbus_pkg::*;

  localparam int unsigned N = 2;
  localparam logic [31:0] A0 = 32'h8000_0000;
  localparam logic [31:0] A1 = 32'h9000_0000;

  logic                 clk;
  logic                 reset;
  cbus_req_t  [N-1:0]   ireqs;
  cbus_resp_t [N-1:0]   iresps;
  cbus_req_t            oreq;
  cbus_resp_t           oresp;

  int n_tests = 0;
  int n_fail  = 0;
  int exp_q[$];
  logic prev_v = 1'b0;

  cbus_rr_arbiter #(.NUM_INPUTS(N)) dut (
    .clk    (clk),
    .reset  (reset),
    .ireqs  (ireqs),
    .iresps (iresps),
    .oreq   (oreq),
    .oresp  (oresp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic cbus_req_t mk(input logic [31:0] addr, input logic [3:0] len);
    cbus_req_t r;
    r        = '0;
    r.valid  = 1'b1;
    r.size   = 3'd2;
    r.addr   = addr;
    r.len    = len;
    r.burst  = (len != 4'd0) ? BURST_INCR : BURST_FIXED;
    return r;
  endfunction

  function automatic cbus_resp_t rsp(input logic rdy, input logic lst, input logic [31:0] d);
    cbus_resp_t r;
    r.ready = rdy;
    r.last  = lst;
    r.data  = d;
    return r;
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Grant-order monitor: each rising oreq.valid is a new transaction.
  always @(negedge clk) begin
    if (!reset && oreq.valid && !prev_v) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_grant", 128'(oreq.addr), 128'(0));
      end else begin
        int e;
        e = exp_q.pop_front();
        chk("grant_order", 128'(oreq.addr), 128'((e == 0) ? A0 : A1));
      end
    end
    prev_v = oreq.valid;
  end

  initial begin
    int exp_g[4];
    int g;

`ifdef CBUS_ARB_RR_EN
    exp_g = '{0, 1, 0, 1};
`else
    exp_g = '{0, 0, 0, 0};
`endif

    reset = 1'b1;
    ireqs = '0;
    oresp = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("reset_oreq", 128'(oreq), 128'(0));
    chk("reset_iresps", 128'(iresps), 128'(0));

    // Single master, single beat: grant in cycle 1, response in cycle 3.
    next_cycle();
    ireqs[0] = mk(A0, 4'd0);
    exp_q.push_back(0);
    @(negedge clk);
    chk("single_c0_valid", 128'(oreq.valid), 128'(0));
    for (int c = 1; c <= 3; c++) begin
      next_cycle();
      if (c == 3) oresp = rsp(1'b1, 1'b1, 32'h1234_5678);
      @(negedge clk);
      chk("single_valid", 128'(oreq.valid), 128'(1));
      chk("single_ready0", 128'(iresps[0].ready), 128'(c == 3));
    end
    chk("single_data0", 128'(iresps[0].data), 128'(32'h1234_5678));
    chk("single_ready1", 128'(iresps[1].ready), 128'(0));
    next_cycle();
    ireqs = '0;
    oresp = '0;
    @(negedge clk);
    chk("single_c4_idle", 128'(oreq.valid), 128'(0));

    // Fresh priority state for contention.
    next_cycle();
    reset = 1'b1;
    next_cycle();
    reset = 1'b0;

    // Contention: both masters request continuously, single beats.
    ireqs[0] = mk(A0, 4'd0);
    ireqs[1] = mk(A1, 4'd0);
    for (int t = 0; t < 4; t++) exp_q.push_back(exp_g[t]);
    for (int t = 0; t < 4; t++) begin
      g = exp_g[t];
      if (t != 0) next_cycle();
      oresp = '0;
      @(negedge clk);
      chk("cont_dead", 128'(oreq.valid), 128'(0));
      next_cycle();
      @(negedge clk);
      chk("cont_grant", 128'(oreq.addr), 128'((g == 0) ? A0 : A1));
      next_cycle();
      oresp = rsp(1'b1, 1'b1, 32'hC0DE_0000 + 32'(t));
      @(negedge clk);
      chk("cont_ready_win", 128'(iresps[g].ready), 128'(1));
      chk("cont_ready_lose", 128'(iresps[1-g].ready), 128'(0));
    end
    next_cycle();
    ireqs = '0;
    oresp = '0;
    @(negedge clk);
    chk("cont_end_idle", 128'(oreq.valid), 128'(0));

    // Burst: DCache 4 beats with a stall, ICache arrives mid-burst.
    next_cycle();
    ireqs[1] = mk(A1, 4'd3);
    exp_q.push_back(1);
    next_cycle();                                   // b+1: grant
    @(negedge clk);
    chk("burst_len", 128'(oreq.len), 128'(3));
    chk("burst_type", 128'(oreq.burst), 128'(BURST_INCR));
    for (int c = 2; c <= 6; c++) begin
      next_cycle();
      if (c == 3) begin
        ireqs[0] = mk(A0, 4'd0);
        exp_q.push_back(0);
      end
      oresp = (c == 5) ? rsp(1'b0, 1'b0, 32'h0)
                       : rsp(1'b1, c == 6, 32'hB000_0000 + 32'(c));
      @(negedge clk);
      chk("burst_hold", 128'(oreq.addr), 128'(A1));
      chk("burst_ready1", 128'(iresps[1].ready), 128'(c != 5));
      chk("burst_ready0", 128'(iresps[0].ready), 128'(0));
    end
    chk("burst_data", 128'(iresps[1].data), 128'(32'hB000_0006));
    next_cycle();                                   // b+7: dead cycle
    ireqs[1] = '0;
    oresp = '0;
    @(negedge clk);
    chk("burst_dead", 128'(oreq.valid), 128'(0));
    next_cycle();                                   // b+8: ICache granted
    @(negedge clk);
    chk("burst_next_grant", 128'(oreq.addr), 128'(A0));
    chk("burst_next_valid", 128'(oreq.valid), 128'(1));
    next_cycle();
    oresp = rsp(1'b1, 1'b1, 32'h0);
    next_cycle();
    ireqs = '0;
    oresp = '0;

    // Reset during beat 2 of a DCache burst.
    next_cycle();
    ireqs[1] = mk(A1, 4'd3);
    exp_q.push_back(1);
    next_cycle();
    for (int c = 2; c <= 4; c++) begin
      next_cycle();
      oresp = rsp(1'b1, 1'b0, 32'h0);
    end
    #2;
    reset = 1'b1;
    @(negedge clk);
    chk("rst_mid_oreq", 128'(oreq), 128'(0));
    chk("rst_mid_iresps", 128'(iresps), 128'(0));
    next_cycle();
    reset = 1'b0;
    ireqs[0] = mk(A0, 4'd0);
    ireqs[1] = mk(A1, 4'd0);
    oresp = '0;
    exp_q.push_back(0);
    @(negedge clk);
    chk("post_rst_idle", 128'(oreq.valid), 128'(0));
    next_cycle();                                   // q+1
    @(negedge clk);
    chk("post_rst_grant0", 128'(oreq.addr), 128'(A0));
    next_cycle();                                   // q+2
    oresp = rsp(1'b1, 1'b1, 32'h0);
    @(negedge clk);
    chk("post_rst_ready0", 128'(iresps[0].ready), 128'(1));
    chk("post_rst_ready1", 128'(iresps[1].ready), 128'(0));
    next_cycle();                                   // q+3
    ireqs[0] = '0;
    oresp = '0;
    exp_q.push_back(1);
    @(negedge clk);
    chk("post_rst_dead", 128'(oreq.valid), 128'(0));

    // Abort: granted DCache drops valid, pending ICache takes over.
    next_cycle();                                   // q+4
    ireqs[0] = mk(A0, 4'd0);
    exp_q.push_back(0);
    @(negedge clk);
    chk("abort_grant1", 128'(oreq.addr), 128'(A1));
    chk("abort_iresp0", 128'(iresps[0]), 128'(0));
    next_cycle();                                   // q+5
    ireqs[1] = '0;
    @(negedge clk);
    chk("abort_drop", 128'(oreq.valid), 128'(0));
    next_cycle();                                   // q+6
    @(negedge clk);
    chk("abort_idle", 128'(oreq.valid), 128'(0));
    next_cycle();                                   // q+7
    @(negedge clk);
    chk("abort_regrant", 128'(oreq.addr), 128'(A0));
    chk("abort_regrant_v", 128'(oreq.valid), 128'(1));
    next_cycle();                                   // q+8
    oresp = rsp(1'b1, 1'b1, 32'h0);
    @(negedge clk);
    chk("abort_ready0", 128'(iresps[0].ready), 128'(1));
    next_cycle();                                   // q+9
    ireqs = '0;
    oresp = '0;
    @(negedge clk);
    chk("final_idle", 128'(oreq), 128'(0));
    chk("grants_consumed", 128'(exp_q.size()), 128'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
